// File: rtl/hv_flt_pkg.sv
// Shared types and defaults for the HV fault conditioning block.
package hv_flt_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, ACT} intb_st_e;

  localparam int unsigned CH_NUM_DEF      = 6;
  localparam int unsigned CNT_W_DEF       = 8;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned INTB_MIN_DEF    = 16;

  function automatic int unsigned id_width(input int unsigned ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/hv_flt_chan.sv
// One fault channel: synchroniser, deglitch counter, detect and status latch.
module hv_flt_chan
  import hv_flt_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flt,
  input  logic             mask,
  input  logic             latch,
  input  logic             clr,
  input  logic [CNT_W-1:0] thr,
  output logic             sts,
  output logic             sts_nxt
);

  logic             s;
  logic [CNT_W-1:0] cnt;
  logic             det;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = flt;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= flt;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (mask || !s) begin
      cnt <= '0;
    end else if (cnt < thr) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign det = s & ~mask & (cnt == thr);

  // Latched mode: detect dominates a coincident clear.
  always_comb begin
    sts_nxt = sts;
    if (mask) begin
      sts_nxt = 1'b0;
    end else if (!latch) begin
      sts_nxt = det;
    end else if (det) begin
      sts_nxt = 1'b1;
    end else if (clr) begin
      sts_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sts <= 1'b0;
    end else begin
      sts <= sts_nxt;
    end
  end

endmodule

// File: rtl/hv_flt_filter.sv
// HV fault conditioning: per-channel filtering plus interrupt, first-fault ID
// and PWM-disable aggregation.
module hv_flt_filter
  import hv_flt_pkg::*;
#(
  parameter int unsigned CH_NUM      = CH_NUM_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned INTB_MIN    = INTB_MIN_DEF,
  localparam int unsigned ID_W       = id_width(CH_NUM)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [CH_NUM-1:0]       i_flt,
  input  logic [CH_NUM-1:0]       i_flt_mask,
  input  logic [CH_NUM-1:0]       i_flt_latch,
  input  logic [CH_NUM-1:0]       i_flt_clr,
  input  logic [CH_NUM*CNT_W-1:0] i_flt_thr,
  input  logic [CH_NUM-1:0]       i_pwm_dis_en,
  output logic [CH_NUM-1:0]       o_flt_sts,
  output logic                    o_flt_any,
  output logic                    o_intb,
  output logic                    o_first_flt_vld,
  output logic [ID_W-1:0]         o_first_flt_id,
  output logic                    o_pwm_dis
);

  localparam int unsigned TMR_W = $clog2(INTB_MIN + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(INTB_MIN - 1);

  logic [CH_NUM-1:0] sts_nxt;
  logic [CH_NUM-1:0] rise;
  logic              any_nxt;
  logic [ID_W-1:0]   rise_id;
  logic              found;
  intb_st_e          state, state_nxt;
  logic [TMR_W-1:0]  timer, timer_nxt;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_chan
    hv_flt_chan #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk     (i_clk),
      .rst     (i_rst),
      .flt     (i_flt[g]),
      .mask    (i_flt_mask[g]),
      .latch   (i_flt_latch[g]),
      .clr     (i_flt_clr[g]),
      .thr     (i_flt_thr[g*CNT_W +: CNT_W]),
      .sts     (o_flt_sts[g]),
      .sts_nxt (sts_nxt[g])
    );
  end

  assign o_flt_any = |o_flt_sts;
  assign any_nxt   = |sts_nxt;
  assign rise      = sts_nxt & ~o_flt_sts;

  always_comb begin
    rise_id = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (rise[i] && !found) begin
        rise_id = ID_W'(i);
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_first_flt_vld <= 1'b0;
      o_first_flt_id  <= '0;
    end else if (o_first_flt_vld && !o_flt_any) begin
      o_first_flt_vld <= 1'b0;
      o_first_flt_id  <= '0;
    end else if (!o_first_flt_vld && found) begin
      o_first_flt_vld <= 1'b1;
      o_first_flt_id  <= rise_id;
    end
  end

  // FSM looks at next-cycle status so o_intb moves on the same edge as o_flt_sts;
  // HOLD expiry with no fault left skips ACT, giving exactly INTB_MIN low cycles.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    case (state)
      IDLE: begin
        if (any_nxt) begin
          state_nxt = HOLD;
          timer_nxt = TMR_LOAD;
        end
      end
      HOLD: begin
        if (timer == '0) begin
          state_nxt = any_nxt ? ACT : IDLE;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      ACT: begin
        if (!any_nxt) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      timer     <= '0;
      o_intb    <= 1'b1;
      o_pwm_dis <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      o_intb    <= (state_nxt == IDLE);
      o_pwm_dis <= |(sts_nxt & i_pwm_dis_en);
    end
  end

endmodule

// File: tb/tb_hv_flt_filter.sv
// Randomised and directed bench for hv_flt_filter against a behavioural model.
module tb_hv_flt_filter;

  localparam int CH = 6;
  localparam int CW = 8;
  localparam int SS = 2;
  localparam int IM = 16;
  localparam int IW = 3;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic [CH-1:0]    i_flt, i_flt_mask, i_flt_latch, i_flt_clr, i_pwm_dis_en;
  logic [CH*CW-1:0] i_flt_thr;
  logic [CH-1:0]    o_flt_sts;
  logic             o_flt_any, o_intb, o_first_flt_vld, o_pwm_dis;
  logic [IW-1:0]    o_first_flt_id;

  int nchk = 0;
  int nerr = 0;

  hv_flt_filter #(
    .CH_NUM      (CH),
    .CNT_W       (CW),
    .SYNC_STAGES (SS),
    .INTB_MIN    (IM)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_flt           (i_flt),
    .i_flt_mask      (i_flt_mask),
    .i_flt_latch     (i_flt_latch),
    .i_flt_clr       (i_flt_clr),
    .i_flt_thr       (i_flt_thr),
    .i_pwm_dis_en    (i_pwm_dis_en),
    .o_flt_sts       (o_flt_sts),
    .o_flt_any       (o_flt_any),
    .o_intb          (o_intb),
    .o_first_flt_vld (o_first_flt_vld),
    .o_first_flt_id  (o_first_flt_id),
    .o_pwm_dis       (o_pwm_dis)
  );

  always #5 i_clk = ~i_clk;

  // Model: raw-input delay line, run length of synced-high unmasked cycles,
  // and the interrupt expressed as "low while any fault or < IM cycles since fall".
  bit [CH-1:0] m_pipe [SS];
  int          m_run [CH];
  bit [CH-1:0] m_sts;
  bit          m_pwm, m_vld, m_intb;
  int          m_id, m_age;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < SS; k++) m_pipe[k] = '0;
    for (int n = 0; n < CH; n++) m_run[n] = 0;
    m_sts = '0; m_pwm = 0; m_vld = 0; m_id = 0; m_intb = 1; m_age = 0;
  endtask

  task automatic model_edge();
    bit [CH-1:0] s, det, nsts, rise;
    int thr_n;
    if (i_rst) begin
      model_reset();
      return;
    end
    s = m_pipe[SS-1];
    for (int n = 0; n < CH; n++) begin
      thr_n  = int'(i_flt_thr[n*CW +: CW]);
      det[n] = s[n] && !i_flt_mask[n] && (m_run[n] >= thr_n);
      if (i_flt_mask[n])        nsts[n] = 0;
      else if (!i_flt_latch[n]) nsts[n] = det[n];
      else                      nsts[n] = det[n] | (m_sts[n] & !i_flt_clr[n]);
      if (s[n] && !i_flt_mask[n]) begin
        if (m_run[n] < 1000) m_run[n]++;
      end else begin
        m_run[n] = 0;
      end
    end
    for (int k = SS - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = i_flt;
    rise = nsts & ~m_sts;
    if (m_vld && m_sts == 0) begin
      m_vld = 0; m_id = 0;
    end else if (!m_vld && rise != 0) begin
      m_vld = 1;
      for (int n = CH - 1; n >= 0; n--) if (rise[n]) m_id = n;
    end
    if (m_intb) begin
      if (nsts != 0) begin
        m_intb = 0; m_age = 0;
      end
    end else begin
      m_age++;
      m_intb = !((nsts != 0) || (m_age < IM));
    end
    m_pwm = |(nsts & i_pwm_dis_en);
    m_sts = nsts;
  endtask

  task automatic compare_all();
    check("sts", o_flt_sts, m_sts);
    check("any", o_flt_any, |m_sts);
    check("intb", o_intb, m_intb);
    check("vld", o_first_flt_vld, m_vld);
    check("id", o_first_flt_id, m_id);
    check("pwm", o_pwm_dis, m_pwm);
  endtask

  task automatic step();
    @(posedge i_clk);
    model_edge();
    #1 compare_all();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    int lowcnt;
    i_rst = 1; i_flt = '0; i_flt_mask = '0; i_flt_latch = '0; i_flt_clr = '0;
    i_flt_thr = '0; i_pwm_dis_en = '0;
    model_reset();
    repeat (2) step();
    check("rst_intb", o_intb, 1);
    check("rst_sts", o_flt_sts, 0);
    #2 i_rst = 0;
    i_flt_thr[0*CW +: CW] = 8'd5;
    i_flt_thr[2*CW +: CW] = 8'd5;
    i_flt_thr[5*CW +: CW] = 8'd3;
    i_pwm_dis_en = 6'b000100;

    // Held fault on ch2, thr=5: rise on the 8th sampling edge.
    i_flt[2] = 1;
    repeat (7) step();
    check("t1_pre", o_flt_sts[2], 0);
    step();
    check("t1_sts", o_flt_sts[2], 1);
    check("t1_intb", o_intb, 0);
    check("t1_vld", o_first_flt_vld, 1);
    check("t1_id", o_first_flt_id, 2);
    check("t1_pwm", o_pwm_dis, 1);
    i_flt[2] = 0;
    repeat (24) step();
    check("t1_idle", {o_intb, o_first_flt_vld}, 2'b10);

    // 5-cycle glitch on ch0 is rejected, a 6-cycle pulse is accepted.
    i_flt[0] = 1;
    seen = 0;
    repeat (5) begin step(); seen |= o_flt_sts[0]; end
    i_flt[0] = 0;
    repeat (12) begin step(); seen |= o_flt_sts[0]; end
    check("t2_glitch", seen, 0);
    check("t2_intb", o_intb, 1);
    i_flt[0] = 1;
    seen = 0;
    repeat (6) begin step(); seen |= o_flt_sts[0]; end
    i_flt[0] = 0;
    repeat (6) begin step(); seen |= o_flt_sts[0]; end
    check("t2_pulse", seen, 1);
    repeat (24) step();

    // Latched ch1: clear ignored while detecting, honoured afterwards.
    i_flt_latch[1] = 1; i_flt[1] = 1;
    repeat (3) step();
    check("t3_set", o_flt_sts[1], 1);
    i_flt_clr[1] = 1; step(); i_flt_clr[1] = 0;
    check("t3_clr_det", o_flt_sts[1], 1);
    i_flt[1] = 0;
    repeat (5) step();
    check("t3_hold", o_flt_sts[1], 1);
    i_flt_clr[1] = 1; step(); i_flt_clr[1] = 0;
    check("t3_clr", o_flt_sts[1], 0);
    i_flt_latch[1] = 0;
    repeat (24) step();

    // One-cycle fault on ch3 with thr=0: minimum interrupt width.
    i_flt[3] = 1; step(); i_flt[3] = 0;
    lowcnt = 0;
    repeat (30) begin step(); if (!o_intb) lowcnt++; end
    check("t4_low", lowcnt, IM);
    check("t4_vld", o_first_flt_vld, 0);

    // Simultaneous ch4/ch1 rise picks the lowest index; later events keep it.
    i_flt_thr[0*CW +: CW] = 8'd0;
    i_flt[4] = 1; i_flt[1] = 1;
    repeat (3) step();
    check("t5_id", o_first_flt_id, 1);
    i_flt[0] = 1;
    repeat (3) step();
    check("t5_ch0", o_flt_sts[0], 1);
    check("t5_id_ch0", o_first_flt_id, 1);
    i_flt_mask[1] = 1; i_flt[4] = 0;
    repeat (4) step();
    check("t5_sts", o_flt_sts, 6'b000001);
    check("t5_id_keep", o_first_flt_id, 1);
    check("t5_vld_keep", o_first_flt_vld, 1);
    i_flt = '0; i_flt_mask = '0;
    repeat (24) step();

    // Asynchronous reset during HOLD with a latched fault, then full latency again.
    i_pwm_dis_en = 6'b001100;
    i_flt_latch[3] = 1; i_flt[3] = 1;
    repeat (5) step();
    check("t6_pre_rst", o_intb, 0);
    #2 i_rst = 1;
    #1 model_reset();
    check("t6_sts", o_flt_sts, 0);
    check("t6_any", o_flt_any, 0);
    check("t6_intb", o_intb, 1);
    check("t6_vld", o_first_flt_vld, 0);
    check("t6_id", o_first_flt_id, 0);
    check("t6_pwm", o_pwm_dis, 0);
    repeat (2) step();
    #2 i_rst = 0;
    repeat (2) step();
    check("t6_relat_pre", o_flt_sts[3], 0);
    step();
    check("t6_relat", o_flt_sts[3], 1);
    i_flt = '0; i_flt_latch = '0; i_flt_clr[3] = 1; step(); i_flt_clr = '0;
    repeat (24) step();

    // Randomised traffic with fixed thresholds.
    repeat (5) step();
    for (int n = 0; n < CH; n++) i_flt_thr[n*CW +: CW] = CW'($urandom_range(0, 4));
    i_flt_latch  = CH'($urandom);
    i_pwm_dis_en = CH'($urandom);
    for (int t = 0; t < 600; t++) begin
      for (int n = 0; n < CH; n++) begin
        if ($urandom_range(0, 4) == 0) i_flt[n] = ~i_flt[n];
        if ($urandom_range(0, 19) == 0) i_flt_mask[n] = ~i_flt_mask[n];
        if ($urandom_range(0, 39) == 0) i_flt_latch[n] = ~i_flt_latch[n];
      end
      i_flt_clr = ($urandom_range(0, 5) == 0) ? CH'($urandom) : '0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
